// File: rtl/ccg_preimage_search_pkg.sv
// Shared types and constants for the pre-image search block.
// Optional MISR build macro: CCG_PREIMAGE_MISR_EN.
package ccg_pkg;

  localparam int CCG_N_IN  = 4;
  localparam int CCG_N_OUT = 19;

  // Feedback taps 19,6,2,1 expressed as bit positions 18,5,1,0.
  localparam logic [18:0] CCG_MISR_TAPS = 19'h40023;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_SAMPLE,
    ST_RESP
  } ccg_state_e;

endpackage

// File: rtl/ccg_preimage_search_if.sv
// Request/response handshake and circuit-under-test bus for the pre-image search.
// rsp_sig exists only when CCG_PREIMAGE_MISR_EN is defined.
interface ccg_preimage_search_if
  import ccg_pkg::*;
#(
  parameter int N_IN  = CCG_N_IN,
  parameter int N_OUT = CCG_N_OUT
);

  logic              req_valid;
  logic              req_ready;
  logic [N_OUT-1:0]  req_target;
  logic [N_OUT-1:0]  req_mask;
  logic [N_IN-1:0]   x_o;
  logic [N_OUT-1:0]  f_i;
  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_found;
  logic [N_IN-1:0]   rsp_x;
  logic [N_IN:0]     rsp_count;
`ifdef CCG_PREIMAGE_MISR_EN
  logic [N_OUT-1:0]  rsp_sig;

  modport slave (
    input  req_valid, req_target, req_mask, f_i, rsp_ready,
    output req_ready, x_o, rsp_valid, rsp_found, rsp_x, rsp_count, rsp_sig
  );
  modport master (
    output req_valid, req_target, req_mask, f_i, rsp_ready,
    input  req_ready, x_o, rsp_valid, rsp_found, rsp_x, rsp_count, rsp_sig
  );
`else
  modport slave (
    input  req_valid, req_target, req_mask, f_i, rsp_ready,
    output req_ready, x_o, rsp_valid, rsp_found, rsp_x, rsp_count
  );
  modport master (
    output req_valid, req_target, req_mask, f_i, rsp_ready,
    input  req_ready, x_o, rsp_valid, rsp_found, rsp_x, rsp_count
  );
`endif

endinterface

// File: rtl/ccg_preimage_search_misr.sv
// 19-bit Fibonacci MISR with enable and synchronous clear; used only when
// CCG_PREIMAGE_MISR_EN is defined.
module ccg_misr
  import ccg_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr_i,
  input  logic        en_i,
  input  logic [18:0] data_i,
  output logic [18:0] sig_o
);

  logic [18:0] sig_q;
  logic [18:0] sig_d;

  always_comb begin
    sig_d = {sig_q[17:0], ^(sig_q & CCG_MISR_TAPS)} ^ data_i;
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clr_i) begin
      sig_q <= '0;
    end else if (en_i) begin
      sig_q <= sig_d;
    end
  end

  assign sig_o = sig_q;

endmodule

// File: rtl/ccg_preimage_search.sv
// Exhaustive input sweep of an attached combinational circuit with masked
// response matching. Optional signature build macro: CCG_PREIMAGE_MISR_EN.
module ccg_preimage_search
  import ccg_pkg::*;
#(
  parameter int N_IN   = CCG_N_IN,
  parameter int N_OUT  = CCG_N_OUT,
  parameter int SETTLE = 1
) (
  input logic                   clk,
  input logic                   rst_n,
  ccg_preimage_search_if.slave  bus
);

  localparam logic [4:0] SETTLE_W = 5'(SETTLE);
  // With no settle delay a pattern goes straight to its sample cycle.
  localparam ccg_state_e ST_FIRST = (SETTLE == 0) ? ST_SAMPLE : ST_DRIVE;

  ccg_state_e        state_q;
  logic [N_IN-1:0]   x_q;
  logic [3:0]        wait_q;
  logic [N_OUT-1:0]  target_q;
  logic [N_OUT-1:0]  mask_q;
  logic              found_q;
  logic [N_IN-1:0]   rsp_x_q;
  logic [N_IN:0]     count_q;
  logic              req_ready_q;
  logic              rsp_valid_q;

  logic              accept_d;
  logic              match_d;

  assign accept_d = req_ready_q & bus.req_valid;
  assign match_d  = (((bus.f_i ^ target_q) & mask_q) == '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      x_q         <= '0;
      wait_q      <= '0;
      target_q    <= '0;
      mask_q      <= '0;
      found_q     <= 1'b0;
      rsp_x_q     <= '0;
      count_q     <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept_d) begin
            target_q    <= bus.req_target;
            mask_q      <= bus.req_mask;
            x_q         <= '0;
            wait_q      <= '0;
            found_q     <= 1'b0;
            rsp_x_q     <= '0;
            count_q     <= '0;
            req_ready_q <= 1'b0;
            state_q     <= ST_FIRST;
          end
        end
        ST_DRIVE: begin
          wait_q <= wait_q + 4'd1;
          if (({1'b0, wait_q} + 5'd1) == SETTLE_W) begin
            state_q <= ST_SAMPLE;
          end
        end
        ST_SAMPLE: begin
          if (match_d) begin
            count_q <= count_q + 1'b1;
            if (!found_q) begin
              found_q <= 1'b1;
              rsp_x_q <= x_q;
            end
          end
          if (&x_q) begin
            rsp_valid_q <= 1'b1;
            state_q     <= ST_RESP;
          end else begin
            x_q     <= x_q + 1'b1;
            wait_q  <= '0;
            state_q <= ST_FIRST;
          end
        end
        ST_RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.x_o       = x_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_found = found_q;
  assign bus.rsp_x     = rsp_x_q;
  assign bus.rsp_count = count_q;

`ifdef CCG_PREIMAGE_MISR_EN
  logic [18:0] sig_w;

  if (N_OUT != 19) begin : g_bad_width
    $error("ccg_preimage_search: MISR requires N_OUT = 19");
  end

  ccg_misr u_misr (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (accept_d),
    .en_i   (state_q == ST_SAMPLE),
    .data_i (bus.f_i),
    .sig_o  (sig_w)
  );

  assign bus.rsp_sig = sig_w;
`endif

endmodule
